// File: rtl/rs_station_pkg.sv
// Shared Tomasulo definitions: function codes and the "value present" tag.
// The per-slot entry record is declared inside rs_station, because its field
// widths follow that instance's DATA_W/TAG_W/OP_W/ENTRIES parameters.
package rs_station_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNEQ = 4'h8;
  // Tag value meaning "operand value already present".
  localparam logic [3:0] TAG_NONE = 4'h0;
endpackage

// File: rtl/rs_station_if.sv
// Issue, CDB and dispatch bundle of one reservation station.
// master = issue stage / CDB / execution-unit side; slave = the station.
interface rs_station_if #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 4
);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_dest;
  logic [TAG_W-1:0]  issue_q1;
  logic [DATA_W-1:0] issue_v1;
  logic [TAG_W-1:0]  issue_q2;
  logic [DATA_W-1:0] issue_v2;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_dest;
  logic [DATA_W-1:0] disp_a;
  logic [DATA_W-1:0] disp_b;
  logic [CNT_W-1:0]  count;

  modport master (
    output issue_valid, issue_op, issue_dest, issue_q1, issue_v1, issue_q2, issue_v2,
    output cdb_valid, cdb_tag, cdb_data, disp_ready,
    input  issue_ready, disp_valid, disp_op, disp_dest, disp_a, disp_b, count
  );
  modport slave (
    input  issue_valid, issue_op, issue_dest, issue_q1, issue_v1, issue_q2, issue_v2,
    input  cdb_valid, cdb_tag, cdb_data, disp_ready,
    output issue_ready, disp_valid, disp_op, disp_dest, disp_a, disp_b, count
  );
endinterface

// File: rtl/rs_station_oldest_select.sv
// Picks the oldest (smallest age) ready slot; one-hot grant plus found flag.
module rs_oldest_select #(
  parameter int ENTRIES = 4,
  parameter int AGE_W   = 2
) (
  input  logic [ENTRIES-1:0]            i_ready,
  input  logic [ENTRIES-1:0][AGE_W-1:0] i_age,
  output logic [ENTRIES-1:0]            o_grant,
  output logic                          o_found
);
  // A slot wins unless another ready slot is older; equal ages (never seen
  // with dense ages) fall back to lowest index so the grant stays one-hot.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && i_ready[j] &&
            ((i_age[j] < i_age[i]) || (i_age[j] == i_age[i] && j < i)))
          o_grant[i] = 1'b0;
      end
    end
  end

  assign o_found = |i_ready;
endmodule

// File: rtl/rs_station.sv
// Generic reservation station: issue with CDB bypass, CDB snooping, and
// oldest-ready dispatch over a valid/ready handshake.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 4
) (
  input logic          i_clock1,
  input logic          i_reset,
  input logic          i_flush,
  rs_station_if.slave  bus
);
  localparam int AGE_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [TAG_W-1:0] W_TAG_NONE = TAG_W'(TAG_NONE);

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v2;
    logic [AGE_W-1:0]  age;
  } rs_entry_t;

  rs_entry_t                     r_ent [ENTRIES];
  logic [CNT_W-1:0]              r_count;
  logic [ENTRIES-1:0]            w_ready, w_grant, w_free, w_cap1, w_cap2;
  logic [ENTRIES-1:0][AGE_W-1:0] w_age;
  logic                          w_found, w_issue_ready, w_issue_fire, w_disp_fire;
  logic                          w_cdb_live;
  rs_entry_t                     w_sel, w_new;

  assign w_cdb_live    = bus.cdb_valid && (bus.cdb_tag != W_TAG_NONE);
  assign w_issue_ready = r_count < CNT_W'(ENTRIES);
  assign w_issue_fire  = bus.issue_valid && w_issue_ready;
  assign w_disp_fire   = w_found && bus.disp_ready;

  // Per-slot readiness, ages for the picker, and CDB capture matches.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i] = r_ent[i].busy && r_ent[i].q1 == W_TAG_NONE && r_ent[i].q2 == W_TAG_NONE;
      w_age[i]   = r_ent[i].age;
      w_cap1[i]  = r_ent[i].busy && w_cdb_live && r_ent[i].q1 == bus.cdb_tag;
      w_cap2[i]  = r_ent[i].busy && w_cdb_live && r_ent[i].q2 == bus.cdb_tag;
    end
  end

  rs_oldest_select #(.ENTRIES(ENTRIES), .AGE_W(AGE_W)) u_sel (
    .i_ready (w_ready),
    .i_age   (w_age),
    .o_grant (w_grant),
    .o_found (w_found)
  );

  // Mux the granted slot; all-zero when nothing is ready.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (w_grant[i]) w_sel = r_ent[i];
  end

  assign bus.disp_valid  = w_found;
  assign bus.disp_op     = w_sel.op;
  assign bus.disp_dest   = w_sel.dest;
  assign bus.disp_a      = w_sel.v1;
  assign bus.disp_b      = w_sel.v2;
  assign bus.issue_ready = w_issue_ready;
  assign bus.count       = r_count;

  // Lowest-index free slot (slots freed this cycle are still busy here).
  always_comb begin
    w_free = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!r_ent[i].busy) begin
        w_free    = '0;
        w_free[i] = 1'b1;
      end
  end

  // Incoming entry, with same-cycle CDB bypass so a wakeup is never lost.
  always_comb begin
    w_new      = '0;
    w_new.busy = 1'b1;
    w_new.op   = bus.issue_op;
    w_new.dest = bus.issue_dest;
    w_new.q1   = bus.issue_q1;
    w_new.v1   = bus.issue_v1;
    w_new.q2   = bus.issue_q2;
    w_new.v2   = bus.issue_v2;
    w_new.age  = AGE_W'(r_count - CNT_W'(w_disp_fire));
    if (w_cdb_live && bus.issue_q1 == bus.cdb_tag) begin
      w_new.q1 = W_TAG_NONE;
      w_new.v1 = bus.cdb_data;
    end
    if (w_cdb_live && bus.issue_q2 == bus.cdb_tag) begin
      w_new.q2 = W_TAG_NONE;
      w_new.v2 = bus.cdb_data;
    end
  end

  // Slot state: clear on reset/flush, else capture, retire, re-age and fill.
  always_ff @(posedge i_clock1) begin
    if (i_reset || i_flush) begin
      for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_cap1[i]) begin
          r_ent[i].q1 <= W_TAG_NONE;
          r_ent[i].v1 <= bus.cdb_data;
        end
        if (w_cap2[i]) begin
          r_ent[i].q2 <= W_TAG_NONE;
          r_ent[i].v2 <= bus.cdb_data;
        end
        if (w_disp_fire && w_grant[i])
          r_ent[i].busy <= 1'b0;
        else if (w_disp_fire && r_ent[i].busy && r_ent[i].age > w_sel.age)
          r_ent[i].age <= r_ent[i].age - AGE_W'(1);
        if (w_issue_fire && w_free[i])
          r_ent[i] <= w_new;
      end
      r_count <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_disp_fire);
    end
  end

  // Tag 0 means "value present", so it cannot name a producer.
  a_dest_nonzero: assert property (@(posedge i_clock1) disable iff (i_reset || i_flush)
    w_issue_fire |-> bus.issue_dest != W_TAG_NONE);
endmodule

// File: tb/tb_rs_station.sv
// Randomized + directed bench for rs_station with an in-order list model.
module tb_rs_station;
  import rs_station_pkg::*;
  localparam int E = 4, DW = 16, TW = 4, OW = 4;

  logic clk = 1'b0;
  logic rst, fl;
  always #5 clk = ~clk;

  rs_station_if #(.ENTRIES(E), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) bus();
  rs_station #(.ENTRIES(E), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
    .i_clock1(clk), .i_reset(rst), .i_flush(fl), .bus(bus)
  );

  typedef struct {
    logic rst, fl, iv, cv, dr;
    logic [3:0] op, dest, q1, q2, ctag;
    logic [15:0] v1, v2, cdata;
  } stim_t;
  // Model entry; list position is its age (front = oldest).
  typedef struct { logic [3:0] op, dest, q1, q2; logic [15:0] v1, v2; } ment_t;
  typedef struct { int cnt; logic ir, dv; logic [3:0] op, dest; logic [15:0] a, b; } st_t;

  ment_t mq[$];
  st_t   sq[$];
  logic [35:0] dq[$];
  int checks = 0, failures = 0;
  bit known = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: status every cycle, plus dispatch scoreboard on each handshake.
  always @(negedge clk) begin
    st_t e;
    logic [35:0] d;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("count", 32'(bus.count), 32'(e.cnt));
      chk("issue_ready", 32'(bus.issue_ready), 32'(e.ir));
      chk("disp_valid", 32'(bus.disp_valid), 32'(e.dv));
      chk("disp_op", 32'(bus.disp_op), 32'(e.op));
      chk("disp_dest", 32'(bus.disp_dest), 32'(e.dest));
      chk("disp_ab", {bus.disp_a, bus.disp_b}, {e.a, e.b});
      if (bus.disp_valid && bus.disp_ready) begin
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL disp_unexpected actual=fire expected=none t=%0t", $time);
        end else begin
          d = dq.pop_front();
          chk("fire_dest", 32'(bus.disp_dest), 32'(d[35:32]));
          chk("fire_ab", {bus.disp_a, bus.disp_b}, d[31:0]);
        end
      end
    end
  end

  function automatic stim_t mk(input logic dr);
    stim_t s;
    s = '{default: '0};
    s.dr = dr;
    return s;
  endfunction

  function automatic stim_t iss(input logic dr, input logic [3:0] op, dest, q1,
                                input logic [15:0] v1, input logic [3:0] q2, input logic [15:0] v2);
    stim_t s;
    s = mk(dr);
    s.iv = 1; s.op = op; s.dest = dest; s.q1 = q1; s.v1 = v1; s.q2 = q2; s.v2 = v2;
    return s;
  endfunction

  // One clock: drive inputs, push expectations, advance the model.
  task automatic cyc(input stim_t s);
    st_t e;
    ment_t n;
    int sel;
    bit ifire, dfire;
    rst = s.rst; fl = s.fl;
    bus.issue_valid = s.iv; bus.issue_op = s.op; bus.issue_dest = s.dest;
    bus.issue_q1 = s.q1; bus.issue_v1 = s.v1; bus.issue_q2 = s.q2; bus.issue_v2 = s.v2;
    bus.cdb_valid = s.cv; bus.cdb_tag = s.ctag; bus.cdb_data = s.cdata;
    bus.disp_ready = s.dr;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].q1 == 0 && mq[i].q2 == 0) sel = i;
    ifire = s.iv && (mq.size() < E);
    dfire = (sel >= 0) && s.dr;
    if (known) begin
      e = '{cnt: mq.size(), ir: mq.size() < E, dv: sel >= 0, op: 0, dest: 0, a: 0, b: 0};
      if (sel >= 0) begin
        e.op = mq[sel].op; e.dest = mq[sel].dest; e.a = mq[sel].v1; e.b = mq[sel].v2;
      end
      sq.push_back(e);
      if (dfire) dq.push_back({mq[sel].dest, mq[sel].v1, mq[sel].v2});
    end
    if (s.rst || s.fl) mq.delete();
    else begin
      if (dfire) mq.delete(sel);
      if (s.cv && s.ctag != 0)
        foreach (mq[i]) begin
          if (mq[i].q1 == s.ctag) begin mq[i].q1 = 0; mq[i].v1 = s.cdata; end
          if (mq[i].q2 == s.ctag) begin mq[i].q2 = 0; mq[i].v2 = s.cdata; end
        end
      if (ifire) begin
        n = '{op: s.op, dest: s.dest, q1: s.q1, v1: s.v1, q2: s.q2, v2: s.v2};
        if (s.cv && s.ctag != 0 && n.q1 == s.ctag) begin n.q1 = 0; n.v1 = s.cdata; end
        if (s.cv && s.ctag != 0 && n.q2 == s.ctag) begin n.q2 = 0; n.v2 = s.cdata; end
        mq.push_back(n);
      end
    end
    if (s.rst) known = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic cdb(input logic dr, input logic [3:0] tag, input logic [15:0] data);
    stim_t s;
    s = mk(dr);
    s.cv = 1; s.ctag = tag; s.cdata = data;
    cyc(s);
  endtask

  task automatic idle(input logic dr, input int n);
    for (int k = 0; k < n; k++) cyc(mk(dr));
  endtask

  initial begin
    stim_t s;
    s = mk(0); s.rst = 1;
    cyc(s); cyc(s);
    idle(1, 1);
    // Ready add dispatches the cycle after issue.
    cyc(iss(1, OP_ADD, 4'd1, 4'd0, 16'd5, 4'd0, 16'd3));
    idle(1, 2);
    // Pending src1 woken by CDB, eligible the following cycle.
    cyc(iss(1, OP_MUL, 4'd2, 4'd7, 16'd0, 4'd0, 16'd2));
    idle(1, 1);
    cdb(1, 4'd7, 16'h0012);
    idle(1, 2);
    // Issue-time bypass on src2.
    s = iss(1, OP_SUB, 4'd3, 4'd0, 16'd1, 4'd9, 16'd0);
    s.cv = 1; s.ctag = 4'd9; s.cdata = 16'h00AA;
    cyc(s);
    idle(1, 2);
    // Fill to full on tag 3, fifth issue ignored, then in-order drain.
    for (int k = 0; k < 5; k++) cyc(iss(1, OP_ADD, 4'(k + 1), 4'd3, 16'd0, 4'd0, 16'(k)));
    cdb(1, 4'd3, 16'h0033);
    idle(1, 5);
    // Stalled consumer: younger entry presented, then older preempts.
    cyc(iss(0, OP_DIV, 4'd5, 4'd2, 16'd0, 4'd0, 16'd7));
    cyc(iss(0, OP_DIV, 4'd6, 4'd4, 16'd0, 4'd0, 16'd8));
    cdb(0, 4'd4, 16'h0044);
    idle(0, 1);
    cdb(0, 4'd2, 16'h0022);
    idle(0, 2);
    idle(1, 3);
    // Flush with issue and CDB in the same cycle, then reset mid-fill.
    for (int k = 0; k < 3; k++) cyc(iss(0, OP_ADD, 4'(k + 1), 4'd5, 16'd0, 4'd0, 16'd0));
    s = iss(1, OP_SUB, 4'd6, 4'd0, 16'd1, 4'd0, 16'd2);
    s.fl = 1; s.cv = 1; s.ctag = 4'd5; s.cdata = 16'h0055;
    cyc(s);
    idle(1, 2);
    for (int k = 0; k < 2; k++) cyc(iss(0, OP_ADD, 4'(k + 1), 4'd0, 16'd1, 4'd0, 16'd2));
    s = iss(1, OP_MUL, 4'd7, 4'd0, 16'd3, 4'd0, 16'd4);
    s.rst = 1; s.cv = 1; s.ctag = 4'd1; s.cdata = 16'h0011;
    cyc(s);
    idle(1, 2);
    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      s = mk($urandom_range(0, 9) < 7);
      s.iv    = $urandom_range(0, 1);
      s.op    = 4'($urandom_range(0, 8));
      s.dest  = 4'($urandom_range(1, 7));
      s.q1    = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7));
      s.q2    = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7));
      s.v1    = 16'($urandom);
      s.v2    = 16'($urandom);
      s.cv    = $urandom_range(0, 9) < 6;
      s.ctag  = 4'($urandom_range(0, 7));
      s.cdata = 16'($urandom);
      s.fl    = $urandom_range(0, 49) == 0;
      s.rst   = $urandom_range(0, 199) == 0;
      cyc(s);
    end
    idle(1, 4);
    @(negedge clk);
    #1;
    chk("disp_drain", 32'(dq.size()), 32'd0);
    chk("status_drain", 32'(sq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised reservation station for the Tomasulo core. It replaces the fixed adder and multiplier tables with one generic block; one instance is used per execution-unit class.
- Accepts one renamed instruction per cycle from the issue stage.
- Snoops the common data bus (CDB) to fill pending operands.
- Dispatches the oldest fully-ready entry to its execution unit using a valid/ready handshake.

Parameters:
ENTRIES, 4, number of station slots (2..16)
DATA_W, 16, operand/result width
TAG_W, 4, producer tag width; tag value 0 means "operand value present"
OP_W, 4, function code width (0000 add, 0001 sub, 0010 mul, 0011 div ...)

Ports:
clock1  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous clear of all entries (branch mispredict)
issue_valid  in  1  issue stage presents an instruction
issue_ready  out  1  station can accept (count < ENTRIES)
issue_op  in  OP_W  function code
issue_dest  in  TAG_W  tag this instruction will broadcast on the CDB (nonzero)
issue_q1  in  TAG_W  src1 producer tag (0 = issue_v1 valid)
issue_v1  in  DATA_W  src1 value
issue_q2  in  TAG_W  src2 producer tag
issue_v2  in  DATA_W  src2 value
cdb_valid  in  1  CDB broadcast this cycle
cdb_tag  in  TAG_W  broadcasting producer tag
cdb_data  in  DATA_W  broadcast result
disp_valid  out  1  a ready entry is presented
disp_ready  in  1  execution unit accepts
disp_op  out  OP_W  function of presented entry
disp_dest  out  TAG_W  destination tag
disp_a  out  DATA_W  src1 operand
disp_b  out  DATA_W  src2 operand
count  out  $clog2(ENTRIES+1)  occupied entries

Behaviour:
- Per-entry state: busy, op, dest, q1, v1, q2, v2, age. The entry is ready when busy and q1==0 and q2==0.
- Reset or flush:
  - all busy cleared; count=0.
  - disp_valid=0, disp_op/dest/a/b=0, issue_ready=1 (for ENTRIES>0).
  - flush has the same effect as reset but leaves no other state.
  - reset/flush override issue, CDB capture and dispatch in the same cycle.
- Issue (issue_valid && issue_ready):
  - writes the lowest-index free slot at the next edge.
  - issue_ready is derived from registered count only. A slot freed by a same-cycle dispatch is not reusable until the next cycle.
- Issue-time CDB bypass: if cdb_valid and cdb_tag==issue_qN (issue_qN != 0), the slot stores qN=0 and vN=cdb_data. This prevents a lost wakeup.
- CDB capture: every busy entry with qN==cdb_tag (nonzero) loads vN=cdb_data and sets qN=0 at the edge. Both operands may match the same broadcast.
- Wakeup latency: an entry woken by the CDB in cycle t is dispatch-eligible in cycle t+1. There is no same-cycle CDB-to-dispatch forwarding.
- Dispatch selection:
  - combinational over registered state: oldest ready entry (smallest age).
  - disp_* are driven from the selected slot; disp_valid=any ready.
  - When disp_valid=0, disp_* outputs are 0.
- Dispatch fire (disp_valid && disp_ready):
  - the selected slot clears busy at the edge.
  - Selection must remain stable while disp_ready is low, unless an older entry becomes ready. A newly ready older entry preempts; the handshake has no hold requirement.
- Age tracking:
  - A new entry's age equals the number of busy entries after this cycle's dispatch.
  - On dispatch, every entry with age greater than the dispatched age decrements.
  - Ages stay a dense 0..count-1 at all times.
- count: next count = count + issue_fire − disp_fire.
- Boundaries:
  - Full (count==ENTRIES): issue_ready=0; issue_valid ignored.
  - Empty: disp_valid=0.
  - Simultaneous issue and dispatch is allowed when not full; count is unchanged.
  - A CDB tag of 0 never matches.
  - issue_dest==0 is illegal; it is flagged by a simulation assertion.

Decomposition:
- Shared package tomasulo_pkg:
  - opcode constants (OP_ADD..OP_BNEQ).
  - TAG_NONE=0.
  - typedef rs_entry_t {busy, op, dest, q1, v1, q2, v2, age}.
- Sub-module rs_oldest_select: combinational age-compare picker over ENTRIES ready bits. It outputs a one-hot grant plus a found flag.

Test Plan:
- Issue add, q1=q2=0, v1=5, v2=3, disp_ready=1 → next cycle disp_valid=1, op=0000, a=5, b=3; count back to 0 after fire.
- Issue mul with q1=7 pending; cdb_valid, tag=7, data=0x0012 at t → disp_valid rises at t+1 with a=0x0012.
- Same-cycle bypass: issue q2=9 while cdb_tag=9, data=0x00AA → entry ready, dispatches next cycle with b=0x00AA.
- Fill 4 entries all waiting on tag 3 (issue order A,B,C,D) → issue_ready=0 and a fifth issue is ignored. Broadcast tag 3 with disp_ready=1 → dispatch order A,B,C,D, one per cycle.
- Entries waiting on tags 2 and 4; hold disp_ready=0; wake tag 4 then tag 2 → presents the tag-4 entry, then switches to the older tag-2 entry once it is ready.
- Three busy entries, assert flush alongside issue_valid and cdb_valid → count=0, disp_valid=0, no entry written. Repeat with reset high mid-fill: same result.
